// File: rtl/systolic_job_scheduler.sv
// Round-robin job scheduler for the shared 8-PE systolic array.
// Each job is sequenced through weight load, bias load, compute and drain, with valid/ready on every beat.
module systolic_job_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    output logic       grant_id,
    output logic       busy,
    input  logic       opnd_valid,
    input  logic [3:0] opnd_data,
    output logic       opnd_ready,
    output logic [3:0] array_data,
    output logic [7:0] pe_weight_en,
    output logic [7:0] pe_bias_en,
    output logic [7:0] pe_acc_en,
    output logic [2:0] drain_sel,
    input  logic [7:0] acc_out,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       res_last,
    input  logic       res_ready
);
    localparam int unsigned N_PE = 8;
    localparam int unsigned IW   = 3;
    localparam int unsigned SW   = 4;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, COMPUTE, DRAIN} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [SW-1:0] step, step_nx;
    logic          rr_ptr, rr_nx;
    logic          grant_nx;
    logic          winner;
    logic          adv;

    assign array_data = opnd_data;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            step     <= '0;
            rr_ptr   <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            step     <= step_nx;
            rr_ptr   <= rr_nx;
            grant_id <= grant_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        step_nx      = step;
        rr_nx        = rr_ptr;
        grant_nx     = grant_id;
        winner       = 1'b0;
        adv          = 1'b0;
        req_ready    = '0;
        opnd_ready   = 1'b0;
        pe_weight_en = '0;
        pe_bias_en   = '0;
        pe_acc_en    = '0;
        drain_sel    = '0;
        res_valid    = 1'b0;
        res_data     = '0;
        res_id       = 1'b0;
        res_last     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    // the pointed-to requester wins whenever it is asking
                    winner            = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
                    req_ready[winner] = 1'b1;
                    grant_nx          = winner;
                    rr_nx             = ~winner;
                    state_nx          = LOAD_W;
                    idx_nx            = '0;
                end
            end
            LOAD_W: begin
                opnd_ready = 1'b1;
                if (opnd_valid) begin
                    pe_weight_en[idx] = 1'b1;
                    idx_nx            = idx + IW'(1);
                    if (idx == IW'(N_PE - 1)) state_nx = LOAD_B;
                end
            end
            LOAD_B: begin
                opnd_ready = 1'b1;
                if (opnd_valid) begin
                    pe_bias_en[idx] = 1'b1;
                    idx_nx          = idx + IW'(1);
                    if (idx == IW'(N_PE - 1)) begin
                        state_nx = COMPUTE;
                        step_nx  = '0;
                    end
                end
            end
            COMPUTE: begin
                // steps 8..14 flush the wavefront without consuming operands
                opnd_ready = (step < SW'(N_PE));
                adv        = (step >= SW'(N_PE)) || opnd_valid;
                if (adv) begin
                    for (int i = 0; i < N_PE; i++) begin
                        pe_acc_en[i] = (5'(i) <= {1'b0, step}) && ({1'b0, step} < 5'(i + N_PE));
                    end
                    step_nx = step + SW'(1);
                    if (step == SW'(2 * N_PE - 2)) begin
                        state_nx = DRAIN;
                        idx_nx   = '0;
                    end
                end
            end
            DRAIN: begin
                drain_sel = idx;
                res_valid = 1'b1;
                res_data  = acc_out;
                res_id    = grant_id;
                res_last  = (idx == IW'(N_PE - 1));
                if (res_ready) begin
                    idx_nx = idx + IW'(1);
                    if (idx == IW'(N_PE - 1)) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Scoreboard bench for systolic_job_scheduler with a behavioural systolic array
// answering on acc_out; expected results come from w*sum(d)+b per PE.
module tb_systolic_job_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       grant_id, busy;
    logic       opnd_valid;
    logic [3:0] opnd_data;
    logic       opnd_ready;
    logic [3:0] array_data;
    logic [7:0] pe_weight_en, pe_bias_en, pe_acc_en;
    logic [2:0] drain_sel;
    logic [7:0] acc_out;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id, res_last;
    logic       res_ready;

    systolic_job_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy), .opnd_valid(opnd_valid), .opnd_data(opnd_data),
        .opnd_ready(opnd_ready), .array_data(array_data), .pe_weight_en(pe_weight_en),
        .pe_bias_en(pe_bias_en), .pe_acc_en(pe_acc_en), .drain_sel(drain_sel),
        .acc_out(acc_out), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_last(res_last), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] wlog[$], blog[$], alog[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         in_feed  = 0;
    bit         log_en   = 0;
    int         res_mode = 0;
    int         res_beats = 0;
    int         hold_cnt = 0;
    logic       rr_m = 1'b0;
    logic [3:0] op_w[8], op_b[8], op_d[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural array: weight/bias latches, data skewed one PE per accumulate step
    logic [7:0] wt_m[8], acc_m[8];
    logic [3:0] pipe_m[8];
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (pe_weight_en[i]) wt_m[i] = 8'(array_data);
            if (pe_bias_en[i])   acc_m[i] = 8'(array_data);
        end
        if (pe_acc_en != 8'h00) begin
            for (int i = 7; i > 0; i--) pipe_m[i] = pipe_m[i-1];
            pipe_m[0] = array_data;
            for (int i = 0; i < 8; i++)
                if (pe_acc_en[i]) acc_m[i] = acc_m[i] + wt_m[i] * 8'(pipe_m[i]);
        end
    end
    assign acc_out = acc_m[drain_sel];

    // monitor: result scoreboard, hold stability, and enable/ready sanity
    bit         hold_prev = 0;
    logic [7:0] prev_data;
    logic [2:0] prev_sel;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_data", 32'(res_data), 32'(prev_data));
                check("hold_sel", 32'(drain_sel), 32'(prev_sel));
            end
            hold_prev = res_valid && !res_ready;
            prev_data = res_data;
            prev_sel  = drain_sel;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h with no expected beat", res_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_id", 32'(res_id), 32'(e.id));
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_last", 32'(res_last), 32'(e.last));
                end
                res_beats++;
            end
            if (in_feed && !opnd_valid)
                check("stall_enables", 32'({pe_weight_en, pe_bias_en, pe_acc_en}), 32'd0);
            if (busy && !in_feed)
                check("opnd_ready_off", 32'(opnd_ready), 32'd0);
            if (log_en) begin
                if (pe_weight_en != 0) wlog.push_back(pe_weight_en);
                if (pe_bias_en != 0)   blog.push_back(pe_bias_en);
                if (pe_acc_en != 0)    alog.push_back(pe_acc_en);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (res_mode)
            1: begin
                if (res_beats == 3 && hold_cnt < 5) begin
                    res_ready = 1'b0;
                    hold_cnt++;
                end else res_ready = 1'b1;
            end
            2: res_ready = ($urandom % 3) != 0;
            default: res_ready = 1'b1;
        endcase
    end

    task automatic wait_idle(input string name);
        int c = 0;
        @(negedge clk);
        while (busy && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy=1 required 0", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_opnd_ready"}, 32'(opnd_ready), 32'd0);
        check({name, "_res_valid"}, 32'(res_valid), 32'd0);
        check({name, "_grant_id"}, 32'(grant_id), 32'd0);
        check({name, "_enables"}, 32'({pe_weight_en, pe_bias_en, pe_acc_en}), 32'd0);
        check({name, "_drain_sel"}, 32'(drain_sel), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rr_m  = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // stall: 0 none, 1 three-cycle gaps at beats 4 and 18, 2 random
    task automatic run_job(input logic [1:0] req, input bit fixed_ops, input int stall,
                           input int rmode, input bit abort, input bit want_latency);
        logic win;
        int   sum, beat, cyc, stall_left;
        bit   first, done4, done18;
        time  t_grant;
        if (!fixed_ops)
            for (int i = 0; i < 8; i++) begin
                op_w[i] = 4'($urandom);
                op_b[i] = 4'($urandom);
                op_d[i] = 4'($urandom);
            end
        wait_idle("pre_job");
        res_mode  = rmode;
        res_beats = 0;
        hold_cnt  = 0;
        @(posedge clk);
        #1 req_valid = req;
        win = req[rr_m] ? rr_m : ~rr_m;
        @(negedge clk);
        check("req_ready", 32'(req_ready), win ? 32'd2 : 32'd1);
        t_grant = $time;
        rr_m = ~win;
        sum = 0;
        for (int i = 0; i < 8; i++) sum += int'(op_d[i]);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.id   = win;
            e.data = 8'(int'(op_b[i]) + int'(op_w[i]) * sum);
            e.last = (i == 7);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        in_feed = 1;
        beat = 0; cyc = 0; stall_left = 0; first = 1; done4 = 0; done18 = 0;
        while (beat < 24 && cyc < 2000) begin
            if (stall == 1) begin
                if (beat == 4 && !done4)   begin stall_left = 3; done4 = 1; end
                if (beat == 18 && !done18) begin stall_left = 3; done18 = 1; end
                opnd_valid = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (stall == 2) begin
                opnd_valid = ($urandom % 4) != 0;
                req_valid  = 2'($urandom);
            end else opnd_valid = 1'b1;
            opnd_data = beat < 8 ? op_w[beat] : beat < 16 ? op_b[beat-8] : op_d[beat-16];
            @(negedge clk);
            cyc++;
            if (first) begin
                check("grant_id", 32'(grant_id), 32'(win));
                check("busy_on", 32'(busy), 32'd1);
                first = 0;
            end
            if (opnd_valid && opnd_ready) beat++;
            @(posedge clk);
            #1;
            if (abort && beat == 22) begin
                in_feed    = 0;
                opnd_valid = 1'b0;
                req_valid  = 2'b00;
                do_reset();
                return;
            end
        end
        if (beat < 24) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout: beats %0d required 24", beat);
        end
        in_feed    = 0;
        req_valid  = 2'b00;
        opnd_valid = (stall == 2) ? 1'($urandom) : 1'b0;
        opnd_data  = 4'($urandom);
        wait_idle("job");
        if (want_latency) check("latency", 32'(($time - t_grant) / 10), 32'd40);
        check("results_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; opnd_valid = 1'b0; opnd_data = 4'h0; res_ready = 1'b1;
        #12;
        check_reset_outputs("por");
        check("array_passthru", 32'(array_data), 32'd0);
        opnd_data = 4'hA;
        #1 check("array_passthru_a", 32'(array_data), 32'hA);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // weights 1..8, zero biases, data 2: enable walks and 40-cycle latency
        for (int i = 0; i < 8; i++) begin
            op_w[i] = 4'(i + 1);
            op_b[i] = 4'h0;
            op_d[i] = 4'h2;
        end
        wlog.delete(); blog.delete(); alog.delete();
        log_en = 1;
        run_job(2'b01, 1, 0, 0, 0, 1);
        log_en = 0;
        check("wlog_len", 32'(wlog.size()), 32'd8);
        check("blog_len", 32'(blog.size()), 32'd8);
        check("alog_len", 32'(alog.size()), 32'd15);
        for (int k = 0; k < 8 && k < wlog.size() && k < blog.size(); k++) begin
            check("weight_walk", 32'(wlog[k]), 32'(1 << k));
            check("bias_walk", 32'(blog[k]), 32'(1 << k));
        end
        for (int s = 0; s < 15 && s < alog.size(); s++) begin
            logic [7:0] m;
            m = 8'h00;
            for (int i = 0; i < 8; i++) if (i <= s && s < i + 8) m[i] = 1'b1;
            check("acc_wave", 32'(alog[s]), 32'(m));
        end

        // simultaneous requests alternate 0, 1, 0 after reset
        do_reset();
        for (int j = 0; j < 3; j++) run_job(2'b11, 0, 0, 0, 0, 0);

        // operand stalls plus result back-pressure on the same fixed job
        for (int i = 0; i < 8; i++) begin
            op_w[i] = 4'(i + 1);
            op_b[i] = 4'h0;
            op_d[i] = 4'h2;
        end
        run_job(2'b01, 1, 1, 1, 0, 0);

        // reset mid-compute, then requester 1 alone
        run_job(2'b01, 0, 0, 0, 1, 0);
        run_job(2'b10, 0, 0, 0, 0, 1);

        for (int j = 0; j < 15; j++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            run_job(r, 0, 2, 2, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
